// File: rtl/d_latch_rst_pkg.sv
// Shared constants and helpers for the latch-emulation bank.
package d_latch_rst_pkg;

  localparam int unsigned DefaultWidth      = 8;
  localparam int unsigned DefaultLanes      = 1;
  localparam int unsigned DefaultResetValue = 0;

  // Bits per independently enabled lane.
  function automatic int unsigned lane_width(input int unsigned width, input int unsigned lanes);
    return width / lanes;
  endfunction

endpackage

// File: rtl/d_latch_rst_cell.sv
// One lane of the bank: a flop-based hold register behind a transparent mux,
// with an asynchronous reset that overrides transparency.
module d_latch_rst_cell #(
  parameter int unsigned      LW          = 8,
  parameter logic [LW-1:0]    RESET_VALUE = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [LW-1:0] d,
  output logic [LW-1:0] q,
  output logic [LW-1:0] q_not
);

  logic [LW-1:0] held_q;
  logic [LW-1:0] held_d;

  // Capture d on every edge while transparent, otherwise keep the held copy.
  always_comb begin
    held_d = held_q;
    if (enable) begin
      held_d = d;
    end
  end

  // Hold register; reset loads RESET_VALUE without waiting for clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held_q <= RESET_VALUE;
    end else begin
      held_q <= held_d;
    end
  end

  // Output path: reset wins, then the zero-latency transparent path, then the held value.
  always_comb begin
    q = held_q;
    if (reset) begin
      q = RESET_VALUE;
    end else if (enable) begin
      q = d;
    end
  end

  assign q_not = ~q;

endmodule

// File: rtl/d_latch_rst_bank.sv
// Bank of latch-emulating lanes; each lane has its own transparency enable.
module d_latch_rst_bank
  import d_latch_rst_pkg::*;
#(
  parameter int unsigned         WIDTH       = DefaultWidth,
  parameter int unsigned         LANES       = DefaultLanes,
  parameter logic [WIDTH-1:0]    RESET_VALUE = WIDTH'(DefaultResetValue)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LANES-1:0] enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_not
);

  localparam int unsigned LW = lane_width(WIDTH, LANES);

  // Lanes must tile the data bus exactly.
  if ((WIDTH % LANES) != 0) begin : g_bad_split
    $error("d_latch_rst_bank: WIDTH (%0d) not divisible by LANES (%0d)", WIDTH, LANES);
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    d_latch_rst_cell #(
      .LW          (LW),
      .RESET_VALUE (RESET_VALUE[i*LW +: LW])
    ) u_cell (
      .clk    (clk),
      .reset  (reset),
      .enable (enable[i]),
      .d      (d[i*LW +: LW]),
      .q      (q[i*LW +: LW]),
      .q_not  (q_not[i*LW +: LW])
    );
  end

endmodule

// File: tb/tb_d_latch_rst_bank.sv
// Directed and randomized checks of the latch-emulation bank.
module tb_d_latch_rst_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: defaults (8 bits, 1 lane, reset value 00).
  logic       rst_a;
  logic [0:0] en_a;
  logic [7:0] d_a, q_a, qn_a;

  // Instance B: two 4-bit lanes.
  logic       rst_b;
  logic [1:0] en_b;
  logic [7:0] d_b, q_b, qn_b;

  // Instance C: four 2-bit lanes, reset value C3.
  logic       rst_c;
  logic [3:0] en_c;
  logic [7:0] d_c, q_c, qn_c;

  d_latch_rst_bank u_dut_a (
    .clk(clk), .reset(rst_a), .enable(en_a), .d(d_a), .q(q_a), .q_not(qn_a)
  );

  d_latch_rst_bank #(.WIDTH(8), .LANES(2)) u_dut_b (
    .clk(clk), .reset(rst_b), .enable(en_b), .d(d_b), .q(q_b), .q_not(qn_b)
  );

  d_latch_rst_bank #(.WIDTH(8), .LANES(4), .RESET_VALUE(8'hC3)) u_dut_c (
    .clk(clk), .reset(rst_c), .enable(en_c), .d(d_c), .q(q_c), .q_not(qn_c)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs may change.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] pattern [3];
  logic [1:0] held_c [4];
  logic [7:0] exp_c;
  logic [7:0] rv_c;

  initial begin
    pattern[0] = 8'h00; pattern[1] = 8'hFF; pattern[2] = 8'h5A;
    rv_c = 8'hC3;
    rst_a = 1'b1; en_a = 1'b0; d_a = 8'h00;
    rst_b = 1'b1; en_b = 2'b00; d_b = 8'h00;
    rst_c = 1'b1; en_c = 4'h0; d_c = 8'h00;

    // Reset hold with toggling data.
    for (int i = 0; i < 5; i++) begin
      tick();
      d_a = pattern[i % 3];
      #1;
      check("rst_hold_q", q_a, 8'h00);
      check("rst_hold_qn", qn_a, 8'hFF);
    end

    // Reset overrides enable.
    en_a = 1'b1; d_a = 8'hFF;
    #1;
    check("rst_over_en_q", q_a, 8'h00);

    // Release with enable high: q follows d immediately.
    tick();
    rst_a = 1'b0; d_a = 8'h00;
    #1;
    check("release_q_00", q_a, 8'h00);
    tick();
    d_a = 8'hFF;
    #1;
    check("release_q_ff", q_a, 8'hFF);

    // Capture A5, then hold while d changes.
    tick();
    d_a = 8'hA5;
    #1;
    check("transp_a5", q_a, 8'hA5);
    tick();
    en_a = 1'b0;
    #1;
    check("hold_q", q_a, 8'hA5);
    for (int i = 0; i < 3; i++) begin
      tick();
      d_a = (i == 0) ? 8'h3C : pattern[i - 1];
      #1;
      check("hold_q_d", q_a, 8'hA5);
      check("hold_qn_d", qn_a, 8'h5A);
    end

    // Asynchronous reset between edges.
    #2;
    rst_a = 1'b1;
    #0;
    check("async_rst_q", q_a, 8'h00);
    check("async_rst_qn", qn_a, 8'hFF);
    tick();
    rst_a = 1'b0;
    #1;
    check("after_rel_q0", q_a, 8'h00);
    tick();
    d_a = 8'h77;
    #1;
    check("after_rel_q1", q_a, 8'h00);

    // Two lanes: low lane transparent, high lane holds its reset value.
    tick();
    rst_b = 1'b0; en_b = 2'b01; d_b = 8'hFF;
    #1;
    check("lanes_ff", q_b, 8'h0F);
    tick();
    d_b = 8'h00;
    #1;
    check("lanes_00", q_b, 8'h00);
    tick();
    en_b = 2'b10; d_b = 8'hAA;
    #1;
    check("lanes_swap", q_b, 8'hA0);
    check("lanes_swap_qn", qn_b, 8'h5F);

    // Non-zero reset value.
    check("rv_q", q_c, 8'hC3);
    check("rv_qn", qn_c, 8'h3C);

    // Randomized run against a per-lane reference model.
    for (int l = 0; l < 4; l++) held_c[l] = rv_c[l*2 +: 2];
    tick();
    rst_c = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      en_c = 4'($urandom_range(0, 15));
      d_c  = 8'($urandom_range(0, 255));
      rst_c = ($urandom_range(0, 19) == 0);
      #1;
      if (rst_c) begin
        exp_c = rv_c;
        for (int l = 0; l < 4; l++) held_c[l] = rv_c[l*2 +: 2];
      end else begin
        for (int l = 0; l < 4; l++) begin
          exp_c[l*2 +: 2] = en_c[l] ? d_c[l*2 +: 2] : held_c[l];
        end
      end
      check("rand_q", q_c, exp_c);
      check("rand_qn", qn_c, ~exp_c);
      // The coming edge captures every transparent lane.
      if (!rst_c) begin
        for (int l = 0; l < 4; l++) begin
          if (en_c[l]) held_c[l] = d_c[l*2 +: 2];
        end
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
